// File: rtl/mux4_rr_arb_if.sv
// mux4_rr_arb_if: requester/consumer bundle for the 4:1 round-robin arbiter.
// master = requester+consumer side, slave = arbiter side.
interface mux4_rr_arb_if #(
    parameter int unsigned WIDTH = 8
);
    logic [3:0]       req;
    logic [3:0]       lock;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic             out_ready;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             out_valid;
    logic [WIDTH-1:0] y;

    modport master (
        output req, lock, d0, d1, d2, d3, out_ready,
        input  gnt, sel, out_valid, y
    );

    modport slave (
        input  req, lock, d0, d1, d2, d3, out_ready,
        output gnt, sel, out_valid, y
    );
endinterface

// File: rtl/mux4_rr_arb.sv
// mux4_rr_arb: round-robin arbiter sharing one registered output word between
// four requesters, with a valid/ready handshake toward the consumer.
// Optional feature: define RR_LOCK_EN to let a locked winner keep the channel
// while it keeps requesting; without it the lock inputs are ignored.
module mux4_rr_arb #(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          reset_n,
    mux4_rr_arb_if.slave bus
);

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0]   y_q, y_d;

    logic               out_valid;
    logic               cap;
    logic               found;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   win;
    logic [WIDTH-1:0]   win_data;

    assign out_valid = (state_q == FULL);
    assign cap       = (|bus.req) && (!out_valid || bus.out_ready);

`ifndef RR_LOCK_EN
    // lock has no effect in the pure round-robin build
    logic unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    // Winner: locked previous winner first (if enabled), else first requester after last
    always_comb begin
        found = 1'b0;
        win   = last_q;
        idx   = last_q;
`ifdef RR_LOCK_EN
        if (bus.lock[last_q] && bus.req[last_q]) begin
            found = 1'b1;
            win   = last_q;
        end
`endif
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = last_q + IDX_W'(k);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Datapath select of the winning requester word
    always_comb begin
        unique case (win)
            2'd0:    win_data = bus.d0;
            2'd1:    win_data = bus.d1;
            2'd2:    win_data = bus.d2;
            default: win_data = bus.d3;
        endcase
    end

    // Next-state: FSM transitions, capture on cap, drop valid on a pure handshake
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        y_d     = y_q;
        gnt_d   = '0;

        unique case (state_q)
            EMPTY: if (|bus.req) state_d = FULL;
            FULL:  if (bus.out_ready) state_d = cap ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase

        if (cap) begin
            y_d    = win_data;
            sel_d  = win;
            last_d = win;
            gnt_d  = NREQ'(1) << win;
        end
    end

    // State and output registers; last resets to 3 so requester 0 goes first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            last_q  <= IDX_W'(3);
            sel_q   <= '0;
            gnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid;
    assign bus.y         = y_q;

endmodule
